// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port fixed-latency SRAM between instruction fetch (IF)
//           and the EX-stage load/store path (DM); one access in flight at a time.
// Latency : request seen in IDLE cycle T -> ack in cycle T+MEM_LAT+2; one access per MEM_LAT+3 cycles.
// Backpressure: requesters hold req until their ack; stall is raised while any request is unacked.
//
// Build option: define ARB_RR_EN for round-robin arbitration between IF and DM.
// Without it, DM wins contested grants, except that after STARVE_MAX consecutive
// DM grants made while IF was waiting, IF wins the next contested grant.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   if_req/if_addr             IF read request and byte address
//   if_rdata/if_ack            IF read data (held between acks) and one-cycle ack
//   dm_req/dm_we/dm_addr/dm_wdata  DM request, 1=store/0=load, address, store data
//   dm_rdata/dm_ack            DM load data (held between acks, not touched by stores), one-cycle ack
//   mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata  SRAM interface, one mem_cs cycle per access
//   stall                      combinational pipeline stall
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int              WCW       = $clog2(MEM_LAT + 1);
  // WAIT lasts MEM_LAT cycles: load MEM_LAT-1 and leave when the counter reads zero.
  localparam logic [WCW-1:0]  WAIT_INIT = WCW'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            owner_dm_q, owner_dm_d;   // 1 = current access belongs to DM
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic            grant_dm;

`ifdef ARB_RR_EN
  logic            last_dm_q, last_dm_d;     // owner of the previous grant; resets to IF

  // Contested grant goes to whoever did not win last time.
  assign grant_dm = dm_req & (~if_req | ~last_dm_q);
`else
  localparam int              SCW        = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0]  STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0]  starve_q, starve_d;

  // DM wins a contested grant until IF has been passed over STARVE_MAX times in a row.
  // starve_q cannot pass STARVE_LIM: at the limit a contested grant always goes to IF.
  assign grant_dm = dm_req & (~if_req | (starve_q < STARVE_LIM));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_dm_q  <= 1'b0;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef ARB_RR_EN
      last_dm_q  <= last_dm_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef ARB_RR_EN
    last_dm_d  = last_dm_q;
`else
    starve_d   = starve_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifndef ARB_RR_EN
        if (!if_req) starve_d = '0;
`endif
        if (if_req || dm_req) begin
          owner_dm_d = grant_dm;
          state_d    = S_ISSUE;
          if (grant_dm) begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
`ifndef ARB_RR_EN
            if (if_req) starve_d = starve_q + 1'b1;
`endif
          end else begin
            we_d   = 1'b0;
            addr_d = if_addr;
`ifndef ARB_RR_EN
            starve_d = '0;
`endif
          end
`ifdef ARB_RR_EN
          last_dm_d = grant_dm;
`endif
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          // Last WAIT cycle: read data is valid now, register it for the DONE cycle.
          if (owner_dm_q) begin
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    mem_cs    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state_q == S_DONE) & ~owner_dm_q;
    dm_ack    = (state_q == S_DONE) & owner_dm_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    stall     = (if_req & ~if_ack) | (dm_req & ~dm_ack);
  end

endmodule
